// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I/D caches, the shared memory port and the arbiter.
// The slave modport is the arbiter's view; master is the view of the caches and memory.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) ();
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one line-wide memory port between I-cache and D-cache, D-cache first.
// Define ARB_FAIRNESS_EN to bound I-cache starvation to MAX_D_BURST consecutive D grants.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned MAX_D_BURST = 4
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);

  if (MAX_D_BURST < 1 || MAX_D_BURST > 15) begin : g_bad_burst
    $error("MAX_D_BURST must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_req;
  logic              grant_i;

  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_FAIRNESS_EN
  logic [3:0] fair_cnt_q, fair_cnt_d;

  // Once D has taken MAX_D_BURST grants in a row with I waiting, I goes next.
  assign grant_i = bus.i_read & (~d_req | (fair_cnt_q == 4'(MAX_D_BURST)));

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (state_q == StIdle) begin
      if (!bus.i_read || grant_i) begin
        fair_cnt_d = 4'd0;
      end else if (d_req) begin
        fair_cnt_d = fair_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fair_cnt_q <= 4'd0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end
`else
  assign grant_i = bus.i_read & ~d_req;
`endif

  always_comb begin
    state_d     = state_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d     = StIBusy;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = bus.i_addr;
        end else if (d_req) begin
          // A simultaneous read+write from the D side is treated as a write-back.
          state_d     = StDBusy;
          mem_read_d  = ~bus.d_write;
          mem_write_d = bus.d_write;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end
      end
      StIBusy: begin
        if (bus.mem_ready) begin
          state_d    = StDone;
          mem_read_d = 1'b0;
          i_ready_d  = 1'b1;
          i_rdata_d  = bus.mem_rdata;
        end
      end
      StDBusy: begin
        if (bus.mem_ready) begin
          state_d     = StDone;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          d_ready_d   = 1'b1;
          if (mem_read_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end
      StDone: begin
        // Dead cycle so the served cache can drop its request before re-arbitration.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.i_ready   = i_ready_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter; expectations follow ARB_FAIRNESS_EN when defined.
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

`ifdef ARB_FAIRNESS_EN
  localparam bit FairEn = 1'b1;
`else
  localparam bit FairEn = 1'b0;
`endif

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_D_BURST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    #1;
    vectors++; if (bus.mem_read !== 1'b0) begin miscompares++;
      $display("FAIL reset_mem_read got %b want 0", bus.mem_read); end
    vectors++; if (bus.mem_write !== 1'b0) begin miscompares++;
      $display("FAIL reset_mem_write got %b want 0", bus.mem_write); end
    vectors++; if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin miscompares++;
      $display("FAIL reset_ready got i=%b d=%b want 0", bus.i_ready, bus.d_ready); end
    vectors++; if (bus.mem_addr !== '0) begin miscompares++;
      $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    vectors++; if (bus.mem_wdata !== '0) begin miscompares++;
      $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
    vectors++; if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin miscompares++;
      $display("FAIL reset_rdata got i=%h d=%h want 0", bus.i_rdata, bus.d_rdata); end
    #4 rst_n = 1'b1;
    #1 clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin miscompares++;
        $display("FAIL idle_no_strobe got r=%b w=%b want 0", bus.mem_read, bus.mem_write); end
    end
  endtask

  task automatic test_i_read();
    logic [DATA_W-1:0] line;
    line = 128'hDEADBEEF_00112233_44556677_8899AABB;
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000123;
    cycle();
    vectors++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin miscompares++;
      $display("FAIL i_grant_strobe got r=%b w=%b want r=1 w=0", bus.mem_read, bus.mem_write); end
    vectors++; if (bus.mem_addr !== 28'h0000123) begin miscompares++;
      $display("FAIL i_grant_addr got %h want 0000123", bus.mem_addr); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++; if (bus.mem_read !== 1'b1 || bus.i_ready !== 1'b0) begin miscompares++;
        $display("FAIL i_wait got r=%b rdy=%b want r=1 rdy=0", bus.mem_read, bus.i_ready); end
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = line;
    cycle();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.i_read    = 1'b0;
    vectors++; if (bus.i_ready !== 1'b1 || bus.mem_read !== 1'b0) begin miscompares++;
      $display("FAIL i_done got rdy=%b r=%b want rdy=1 r=0", bus.i_ready, bus.mem_read); end
    vectors++; if (bus.i_rdata !== line) begin miscompares++;
      $display("FAIL i_rdata got %h want %h", bus.i_rdata, line); end
    cycle();
    vectors++; if (bus.i_ready !== 1'b0 || bus.i_rdata !== line) begin miscompares++;
      $display("FAIL i_pulse_end got rdy=%b data=%h want rdy=0 data held",
               bus.i_ready, bus.i_rdata); end
  endtask

  task automatic test_d_write();
    logic [DATA_W-1:0] wline;
    wline = {16{8'hA5}};
    bus.d_write = 1'b1;
    bus.d_addr  = 28'h00000FF;
    bus.d_wdata = wline;
    cycle();
    vectors++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin miscompares++;
      $display("FAIL d_wr_strobe got w=%b r=%b want w=1 r=0", bus.mem_write, bus.mem_read); end
    vectors++; if (bus.mem_addr !== 28'h00000FF || bus.mem_wdata !== wline) begin miscompares++;
      $display("FAIL d_wr_bus got a=%h d=%h want a=00000ff d=%h",
               bus.mem_addr, bus.mem_wdata, wline); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h1111;
    cycle();
    bus.mem_ready = 1'b0;
    bus.d_write   = 1'b0;
    vectors++; if (bus.d_ready !== 1'b1 || bus.mem_write !== 1'b0) begin miscompares++;
      $display("FAIL d_wr_done got rdy=%b w=%b want rdy=1 w=0", bus.d_ready, bus.mem_write); end
    vectors++; if (bus.d_rdata !== '0) begin miscompares++;
      $display("FAIL d_wr_rdata got %h want 0", bus.d_rdata); end
    cycle();
    vectors++; if (bus.d_ready !== 1'b0) begin miscompares++;
      $display("FAIL d_wr_pulse_end got %b want 0", bus.d_ready); end
  endtask

  task automatic test_simultaneous();
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0AAAAAA;
    bus.d_read = 1'b1;
    bus.d_addr = 28'h0BBBBBB;
    cycle();
    vectors++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0BBBBBB) begin miscompares++;
      $display("FAIL sim_d_first got r=%b a=%h want r=1 a=0bbbbbb", bus.mem_read, bus.mem_addr); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hC0FFEE;
    cycle();
    bus.mem_ready = 1'b0;
    bus.d_read    = 1'b0;
    vectors++; if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0 || bus.d_rdata !== 128'hC0FFEE)
      begin miscompares++;
      $display("FAIL sim_d_done got drdy=%b irdy=%b d=%h want 1 0 c0ffee",
               bus.d_ready, bus.i_ready, bus.d_rdata); end
    cycle();
    vectors++; if (bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0BBBBBB) begin miscompares++;
      $display("FAIL sim_done_hold got r=%b a=%h want r=0 a=0bbbbbb", bus.mem_read, bus.mem_addr); end
    cycle();
    vectors++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0AAAAAA) begin miscompares++;
      $display("FAIL sim_i_next got r=%b a=%h want r=1 a=0aaaaaa", bus.mem_read, bus.mem_addr); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hBEEF;
    cycle();
    bus.mem_ready = 1'b0;
    bus.i_read    = 1'b0;
    vectors++; if (bus.i_ready !== 1'b1 || bus.i_rdata !== 128'hBEEF) begin miscompares++;
      $display("FAIL sim_i_done got rdy=%b d=%h want 1 beef", bus.i_ready, bus.i_rdata); end
    cycle();
  endtask

  task automatic test_fairness();
    bit exp_i;
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000111;
    bus.d_read = 1'b1;
    bus.d_addr = 28'h0000222;
    for (int g = 1; g <= 5; g++) begin
      exp_i = FairEn && (g == 5);
      cycle();
      vectors++;
      if (bus.mem_addr !== (exp_i ? 28'h0000111 : 28'h0000222) || bus.mem_read !== 1'b1) begin
        miscompares++;
        $display("FAIL fair_grant%0d got a=%h r=%b want i_grant=%b", g, bus.mem_addr,
                 bus.mem_read, exp_i);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 128'(g);
      cycle();
      bus.mem_ready = 1'b0;
      vectors++;
      if (bus.i_ready !== exp_i || bus.d_ready !== !exp_i) begin
        miscompares++;
        $display("FAIL fair_ready%0d got i=%b d=%b want i=%b", g, bus.i_ready, bus.d_ready, exp_i);
      end
      if (g == 5) begin
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
      end
      cycle();
    end
    cycle();
  endtask

  task automatic test_reset_mid_busy();
    bus.d_read = 1'b1;
    bus.d_addr = 28'h0000333;
    cycle();
    vectors++; if (bus.mem_read !== 1'b1) begin miscompares++;
      $display("FAIL rst_busy_pre got %b want 1", bus.mem_read); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.mem_read !== 1'b0 || bus.d_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_busy_async got r=%b rdy=%b want 0 0", bus.mem_read, bus.d_ready); end
    bus.d_read = 1'b0;
    #2 rst_n = 1'b1;
    cycle();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h5555;
    cycle();
    bus.mem_ready = 1'b0;
    vectors++; if (bus.d_ready !== 1'b0 || bus.i_ready !== 1'b0 || bus.d_rdata !== '0) begin
      miscompares++;
      $display("FAIL rst_busy_stale got drdy=%b irdy=%b d=%h want 0 0 0",
               bus.d_ready, bus.i_ready, bus.d_rdata); end
    cycle();
  endtask

  initial begin
    bus.i_read    = 1'b0;
    bus.i_addr    = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_fairness();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one external line-wide memory port between the I-cache and the D-cache miss/write-back paths of the pipelined RISC-V core. Each cache raises a read or write request and holds it until it gets a one-cycle ready pulse. The arbiter grants one requester at a time, drives the registered memory strobes, and returns read data. The D-cache has priority, and an optional fairness counter bounds I-cache starvation.

## Interface
Parameters:
- ADDR_W, 28, line address width (byte address bits [31:4]).
- DATA_W, 128, line width in bits.
- MAX_D_BURST, 4, consecutive D grants allowed while I waits (fairness only); legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_read  input  1  I-cache line read request, held until i_ready.
- i_addr  input  ADDR_W  I-cache line address.
- i_ready  output  1  one-cycle pulse: i_rdata valid, request done.
- i_rdata  output  DATA_W  registered line for the I-cache.
- d_read  input  1  D-cache line read request, held until d_ready.
- d_write  input  1  D-cache write-back request, held until d_ready.
- d_addr  input  ADDR_W  D-cache line address.
- d_wdata  input  DATA_W  write-back line.
- d_ready  output  1  one-cycle completion pulse for the D-cache.
- d_rdata  output  DATA_W  registered line for the D-cache.
- mem_read  output  1  memory read strobe, held until mem_ready.
- mem_write  output  1  memory write strobe, held until mem_ready.
- mem_addr  output  ADDR_W  registered memory address.
- mem_wdata  output  DATA_W  registered memory write data.
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready.
- mem_ready  input  1  one-cycle memory completion pulse.

## Operation
- The FSM has four states: IDLE, I_BUSY, D_BUSY, DONE.
- **IDLE.** Requests are evaluated and the chosen owner is latched.
  - A D request (d_read or d_write) goes to D_BUSY. An I request goes to I_BUSY.
  - If both are pending, D wins, except when the fairness override fires (see Configuration).
  - On the transition, mem_addr and mem_wdata are loaded from the winner, and mem_read/mem_write are set.
- **D-side encoding.** d_write=1 gives mem_write=1 and mem_read=0. d_read=1 with d_write=0 gives mem_read=1. If d_read and d_write are both 1, the request is a write.
- **I_BUSY / D_BUSY.**
  - Strobes, address and write data are held stable.
  - New requests are ignored; the other requester keeps waiting.
  - When mem_ready=1: strobes clear, the owner's ready pulses for exactly one cycle, and the state goes to DONE.
  - A read loads mem_rdata into the owner's rdata register. A D write leaves d_rdata unchanged.
- **DONE.** One dead cycle. Requests are ignored, which lets the served cache drop its request so it is not granted twice. The state then returns to IDLE.
- **Data outputs.** i_rdata and d_rdata hold their last loaded value until the next read completion for that side.
- **mem_ready outside BUSY states.** mem_ready arriving in IDLE or DONE is ignored.

## Timing
- **Reset values.** State IDLE. i_ready=0, d_ready=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0, fairness counter=0.
- **Latency.** A request first seen in IDLE at edge N puts the memory strobe high after edge N. mem_ready sampled at edge M puts ready high after edge M, for that one cycle. IDLE is re-entered after edge M+1.
- **Minimum turnaround.** A memory that answers in one cycle gives 3 cycles per transaction (IDLE, BUSY, DONE).
- **Requester rules.** Requests must be held until ready. Requesters deassert in the cycle after ready (the DONE cycle).
- **Reset mid-transaction.** Strobes and ready drop immediately (asynchronous). The memory transaction is abandoned.

## Configuration
- **Macro: ARB_FAIRNESS_EN.**
- **Defined.**
  - A 4-bit counter increments on each D grant made while i_read is pending.
  - It clears on any I grant, and on any IDLE cycle where i_read=0.
  - When the counter equals MAX_D_BURST and i_read=1 in IDLE, I wins even if a D request is pending.
- **Undefined.** No counter exists and D has strict priority. I can starve indefinitely under continuous D traffic.

## Test plan
- **Reset.** Pulse rst_n low with clk stopped -> all outputs 0 immediately and state IDLE; after release, no strobes until a request.
- **I read.** i_read with i_addr=0x0000123, memory returns 0xDEADBEEF_00112233_44556677_8899AABB after 5 cycles -> mem_read=1 with mem_addr=0x0000123 from the cycle after the request; i_ready pulses 1 cycle with that data; the next grant comes no earlier than 2 cycles later.
- **D write.** d_write with d_addr=0x00000FF, d_wdata=0xA5 repeated -> mem_write=1, mem_read=0, mem_wdata matches; d_ready pulses once; d_rdata unchanged.
- **Simultaneous requests.** i_read and d_read in the same IDLE cycle -> D served first; I served immediately after D's DONE cycle; mem_addr switches only on the IDLE->BUSY edge.
- **Fairness.** MAX_D_BURST=4, D requests back-to-back with i_read held -> with ARB_FAIRNESS_EN, the 5th grant goes to I; without it, I is not granted while D keeps requesting.
- **Reset mid-BUSY.** Assert rst_n while mem_read=1 -> mem_read drops asynchronously; an already-scheduled mem_ready after release produces no ready pulse.
